// File: rtl/hwpe_cmd_seq.sv
// hwpe_cmd_seq: issues the custom-instruction command stream that programs
// and runs one accelerator layer.  A start pulse captures the layer
// configuration; the sequencer then walks RST, WCFG, WFAD (4), WACC (128),
// MATRIX and the per-tile drain commands, one valid/ready handshake per
// command, and ends with a one-cycle done pulse.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle layer start pulse (ignored while busy)
//   cfg_*                  layer configuration, sampled on start
//   cmd_valid/cmd_ready    command handshake
//   cmd_inst/rs1/rs2       instruction word and operands (registered)
//   busy, done             sequence in progress, completion pulse
module hwpe_cmd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cfg_kernel_size,
  input  logic [1:0]  cfg_data_type,
  input  logic        cfg_layer_type,
  input  logic        cfg_kernel_333,
  input  logic [9:0]  cfg_k_count,
  input  logic [15:0] cfg_h_count,
  input  logic [15:0] cfg_w_count,
  input  logic [15:0] cfg_h_stride,
  input  logic [15:0] cfg_w_stride,
  input  logic [15:0] cfg_ch_count,
  input  logic [15:0] cfg_w_offset,
  input  logic [4:0]  cfg_acc_shift,
  input  logic [31:0] cfg_addr2_start,
  input  logic        cfg_relu_mode,
  input  logic [31:0] cfg_relu_addr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_inst,
  output logic [31:0] cmd_rs1,
  output logic [31:0] cmd_rs2,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WCFG, S_WFAD, S_WACC, S_MATRIX, S_TILE, S_DONE
  } state_t;

  // Packs the custom instruction fields around the fixed opcode.
  function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [4:0] rs2f,
                                          input logic [4:0] rs1f, input logic [2:0] xflags,
                                          input logic [4:0] rd);
    return {f7, rs2f, rs1f, xflags, rd, 7'b0001011};
  endfunction

  state_t      r_state;
  logic        r_cmd_valid, r_busy, r_done;
  logic [31:0] r_cmd_inst, r_cmd_rs1, r_cmd_rs2;
  logic [3:0]  r_kernel_size;
  logic [1:0]  r_data_type;
  logic        r_layer_type, r_kernel_333, r_relu_mode;
  logic [9:0]  r_k_count;
  logic [15:0] r_h_count, r_w_count, r_h_stride, r_w_stride, r_ch_count, r_w_offset;
  logic [4:0]  r_acc_shift;
  logic [31:0] r_addr2, r_relu_addr;
  logic [1:0]  r_idx;
  logic [2:0]  r_row;
  logic [3:0]  r_pe;
  logic [15:0] r_h, r_w;
  logic [9:0]  r_k;

  logic [1:0]  w_idx_n, w_g_idx;
  logic [2:0]  w_row_n, w_g_row;
  logic [3:0]  w_pe_n, w_g_pe;
  logic [15:0] w_h_n, w_w_n, w_g_h, w_g_w;
  logic [9:0]  w_k_n, w_g_k;
  logic        w_phase_end, w_tile_end, w_final_tile, w_last_cmd, w_base_zero;
  logic [4:0]  w_acc;
  logic [31:0] w_p, w_mult, w_inst, w_rs1, w_rs2;
  state_t      w_state_n;

  assign cmd_valid = r_cmd_valid;
  assign cmd_inst  = r_cmd_inst;
  assign cmd_rs1   = r_cmd_rs1;
  assign cmd_rs2   = r_cmd_rs2;
  assign busy      = r_busy;
  assign done      = r_done;

  // Counter values after accepting the current command, and end-of-phase flag.
  always_comb begin
    w_idx_n = r_idx + 2'd1;
    w_row_n = r_row;
    w_pe_n  = r_pe;
    w_h_n   = r_h;
    w_w_n   = r_w;
    w_k_n   = r_k;
    w_tile_end  = 1'b0;
    w_phase_end = 1'b0;
    case (r_state)
      S_RST, S_WCFG, S_MATRIX: w_phase_end = 1'b1;
      S_WFAD: w_phase_end = (r_idx == 2'd3);
      S_WACC: begin
        if (r_pe == 4'd15) begin
          w_pe_n = 4'd0;
          w_row_n = r_row + 3'd1;
          w_phase_end = (r_row == 3'd7);
        end else begin
          w_pe_n = r_pe + 4'd1;
        end
      end
      S_TILE: begin
        if (r_relu_mode) begin
          w_row_n = r_row + 3'd1;
          w_tile_end = (r_row == 3'd7);
        end else if (r_pe == 4'd15) begin
          w_pe_n = 4'd0;
          w_row_n = r_row + 3'd1;
          w_tile_end = (r_row == 3'd7);
        end else begin
          w_pe_n = r_pe + 4'd1;
        end
        // Tile loop: h innermost, then w, then k.
        if (w_tile_end) begin
          if (r_h == r_h_count - 16'd1) begin
            w_h_n = 16'd0;
            if (r_w == r_w_count - 16'd1) begin
              w_w_n = 16'd0;
              if (r_k == r_k_count - 10'd1) begin
                w_phase_end = 1'b1;
              end else begin
                w_k_n = r_k + 10'd1;
              end
            end else begin
              w_w_n = r_w + 16'd1;
            end
          end else begin
            w_h_n = r_h + 16'd1;
          end
        end else begin
          w_phase_end = 1'b0;
        end
      end
      default: w_phase_end = 1'b0;
    endcase
  end

  // Following phase once the final command of the current one is accepted.
  always_comb begin
    case (r_state)
      S_RST:    w_state_n = S_WCFG;
      S_WCFG:   w_state_n = S_WFAD;
      S_WFAD:   w_state_n = S_WACC;
      S_WACC:   w_state_n = S_MATRIX;
      S_MATRIX: w_state_n = ((r_k_count == 10'd0) || (r_w_count == 16'd0) ||
                             (r_h_count == 16'd0)) ? S_DONE : S_TILE;
      S_TILE:   w_state_n = S_DONE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // Command generator: on phase entry it encodes the current (zeroed) counters,
  // while a command is outstanding it pre-encodes the one after it.
  always_comb begin
    w_g_idx = r_cmd_valid ? w_idx_n : r_idx;
    w_g_row = r_cmd_valid ? w_row_n : r_row;
    w_g_pe  = r_cmd_valid ? w_pe_n  : r_pe;
    w_g_h   = r_cmd_valid ? w_h_n   : r_h;
    w_g_w   = r_cmd_valid ? w_w_n   : r_w;
    w_g_k   = r_cmd_valid ? w_k_n   : r_k;
    w_final_tile = (w_g_k == r_k_count - 10'd1) && (w_g_w == r_w_count - 16'd1) &&
                   (w_g_h == r_h_count - 16'd1);
    w_last_cmd = r_relu_mode ? (w_g_row == 3'd7) : ((w_g_row == 3'd7) && (w_g_pe == 4'd15));
    // The last drain command of a non-final tile flags the accumulator hand-over.
    w_acc = {(w_last_cmd && !w_final_tile) ? 2'b10 : 2'b00, w_g_row};
    w_p = {16'd0, r_h_count} * {16'd0, r_h_stride};
    case (w_g_idx)
      2'd0:    w_mult = 32'd0;
      2'd1:    w_mult = w_p;
      2'd2:    w_mult = w_p << 1;
      default: w_mult = (w_p << 1) + w_p;
    endcase
    w_base_zero = r_kernel_333 && w_g_idx[1];
    w_inst = 32'd0;
    w_rs1  = 32'd0;
    w_rs2  = 32'd0;
    case (r_state)
      S_RST: w_inst = mk_inst(7'd64, 5'd0, 5'd0, 3'b000, 5'd0);
      S_WCFG: begin
        w_inst = mk_inst(7'd2, 5'd0, 5'd0, 3'b011, 5'd0);
        w_rs1  = {r_w_offset, r_ch_count};
        w_rs2  = {9'd0, r_k_count, r_acc_shift, r_kernel_333, r_layer_type,
                  r_data_type, r_kernel_size};
      end
      S_WFAD: begin
        w_inst = mk_inst(7'd1, 5'd0, 5'd0, 3'b011, {2'b00, w_g_idx, 1'b0});
        w_rs1  = w_base_zero ? 32'd0 : w_mult;
        w_rs2  = w_base_zero ? 32'd0 : (r_addr2 + w_mult);
      end
      S_WACC: w_inst = mk_inst(7'd8, {1'b0, w_g_pe}, 5'd0, 3'b010, {2'b00, w_g_row});
      S_MATRIX: begin
        w_inst = mk_inst(7'd4, 5'd0, 5'd0, 3'b011, 5'd0);
        w_rs1  = {r_w_count, r_h_count};
        w_rs2  = {r_w_stride, r_h_stride};
      end
      S_TILE: begin
        if (r_relu_mode) begin
          w_inst = mk_inst(7'd32, w_acc, 5'd0, 3'b010, 5'd0);
          w_rs1  = r_relu_addr;
        end else begin
          w_inst = mk_inst(7'd16, {1'b0, w_g_pe}, w_acc, 3'b100, 5'd0);
        end
      end
      default: w_inst = 32'd0;
    endcase
  end

  // Sequencer FSM with registered command, busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_inst <= 32'd0;
      r_cmd_rs1 <= 32'd0;
      r_cmd_rs2 <= 32'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_kernel_size <= 4'd0;
      r_data_type <= 2'd0;
      r_layer_type <= 1'b0;
      r_kernel_333 <= 1'b0;
      r_relu_mode <= 1'b0;
      r_k_count <= 10'd0;
      r_h_count <= 16'd0;
      r_w_count <= 16'd0;
      r_h_stride <= 16'd0;
      r_w_stride <= 16'd0;
      r_ch_count <= 16'd0;
      r_w_offset <= 16'd0;
      r_acc_shift <= 5'd0;
      r_addr2 <= 32'd0;
      r_relu_addr <= 32'd0;
      r_idx <= 2'd0;
      r_row <= 3'd0;
      r_pe <= 4'd0;
      r_h <= 16'd0;
      r_w <= 16'd0;
      r_k <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_kernel_size <= cfg_kernel_size;
            r_data_type <= cfg_data_type;
            r_layer_type <= cfg_layer_type;
            r_kernel_333 <= cfg_kernel_333;
            r_relu_mode <= cfg_relu_mode;
            r_k_count <= cfg_k_count;
            r_h_count <= cfg_h_count;
            r_w_count <= cfg_w_count;
            r_h_stride <= cfg_h_stride;
            r_w_stride <= cfg_w_stride;
            r_ch_count <= cfg_ch_count;
            r_w_offset <= cfg_w_offset;
            r_acc_shift <= cfg_acc_shift;
            r_addr2 <= cfg_addr2_start;
            r_relu_addr <= cfg_relu_addr;
            r_busy <= 1'b1;
            r_state <= S_RST;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          if (!r_cmd_valid) begin
            r_cmd_valid <= 1'b1;
            r_cmd_inst <= w_inst;
            r_cmd_rs1 <= w_rs1;
            r_cmd_rs2 <= w_rs2;
          end else if (cmd_ready) begin
            if (w_phase_end) begin
              r_cmd_valid <= 1'b0;
              r_cmd_inst <= 32'd0;
              r_cmd_rs1 <= 32'd0;
              r_cmd_rs2 <= 32'd0;
              r_idx <= 2'd0;
              r_row <= 3'd0;
              r_pe <= 4'd0;
              r_h <= 16'd0;
              r_w <= 16'd0;
              r_k <= 10'd0;
              r_state <= w_state_n;
              if (w_state_n == S_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
              end
            end else begin
              r_cmd_inst <= w_inst;
              r_cmd_rs1 <= w_rs1;
              r_cmd_rs2 <= w_rs2;
              r_idx <= w_idx_n;
              r_row <= w_row_n;
              r_pe <= w_pe_n;
              r_h <= w_h_n;
              r_w <= w_w_n;
              r_k <= w_k_n;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_cmd_seq.sv
// Self-checking bench for hwpe_cmd_seq: a reference model fills a queue with
// the expected {inst, rs1, rs2} stream for each layer configuration, and every
// accepted command is popped and compared.
module tb_hwpe_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  cfg_kernel_size = 4'd0;
  logic [1:0]  cfg_data_type = 2'd0;
  logic        cfg_layer_type = 1'b0;
  logic        cfg_kernel_333 = 1'b0;
  logic [9:0]  cfg_k_count = 10'd0;
  logic [15:0] cfg_h_count = 16'd0, cfg_w_count = 16'd0;
  logic [15:0] cfg_h_stride = 16'd0, cfg_w_stride = 16'd0;
  logic [15:0] cfg_ch_count = 16'd0, cfg_w_offset = 16'd0;
  logic [4:0]  cfg_acc_shift = 5'd0;
  logic [31:0] cfg_addr2_start = 32'd0;
  logic        cfg_relu_mode = 1'b0;
  logic [31:0] cfg_relu_addr = 32'd0;
  logic        cmd_valid, busy, done;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_inst, cmd_rs1, cmd_rs2;

  hwpe_cmd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_kernel_size(cfg_kernel_size), .cfg_data_type(cfg_data_type),
    .cfg_layer_type(cfg_layer_type), .cfg_kernel_333(cfg_kernel_333),
    .cfg_k_count(cfg_k_count), .cfg_h_count(cfg_h_count), .cfg_w_count(cfg_w_count),
    .cfg_h_stride(cfg_h_stride), .cfg_w_stride(cfg_w_stride),
    .cfg_ch_count(cfg_ch_count), .cfg_w_offset(cfg_w_offset),
    .cfg_acc_shift(cfg_acc_shift), .cfg_addr2_start(cfg_addr2_start),
    .cfg_relu_mode(cfg_relu_mode), .cfg_relu_addr(cfg_relu_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ks;
    logic [1:0]  dt;
    logic        lt;
    logic        k333;
    logic [9:0]  k;
    logic [15:0] h, w, hs, ws, ch, wo;
    logic [4:0]  sh;
    logic [31:0] a2;
    logic        relu;
    logic [31:0] ra;
  } cfg_t;

  logic [95:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [2:0] x,
                                     input logic [4:0] rd);
    return {f7, r2, r1, x, rd, 7'b0001011};
  endfunction

  task automatic build_model(input cfg_t c);
    logic [31:0] p;
    logic [31:0] b[8];
    int t_total;
    logic [4:0] acc;
    exp_q.delete();
    p = 32'(c.h) * 32'(c.hs);
    b[0] = 32'd0; b[1] = c.a2; b[2] = p; b[3] = c.a2 + p;
    if (c.k333) begin
      b[4] = 32'd0; b[5] = 32'd0; b[6] = 32'd0; b[7] = 32'd0;
    end else begin
      b[4] = p + p; b[5] = c.a2 + p + p; b[6] = p * 32'd3; b[7] = c.a2 + p * 32'd3;
    end
    exp_q.push_back({mk(7'd64, 5'd0, 5'd0, 3'b000, 5'd0), 32'd0, 32'd0});
    exp_q.push_back({mk(7'd2, 5'd0, 5'd0, 3'b011, 5'd0), c.wo, c.ch,
                     9'd0, c.k, c.sh, c.k333, c.lt, c.dt, c.ks});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({mk(7'd1, 5'd0, 5'd0, 3'b011, 5'(2 * i)), b[2 * i], b[2 * i + 1]});
    for (int row = 0; row < 8; row++)
      for (int pe = 0; pe < 16; pe++)
        exp_q.push_back({mk(7'd8, 5'(pe), 5'd0, 3'b010, 5'(row)), 32'd0, 32'd0});
    exp_q.push_back({mk(7'd4, 5'd0, 5'd0, 3'b011, 5'd0), c.w, c.h, c.ws, c.hs});
    t_total = int'(c.k) * int'(c.w) * int'(c.h);
    for (int t = 0; t < t_total; t++)
      for (int row = 0; row < 8; row++) begin
        if (c.relu) begin
          acc = (row == 7 && t != t_total - 1) ? 5'(16 + row) : 5'(row);
          exp_q.push_back({mk(7'd32, acc, 5'd0, 3'b010, 5'd0), c.ra, 32'd0});
        end else begin
          for (int pe = 0; pe < 16; pe++) begin
            acc = (row == 7 && pe == 15 && t != t_total - 1) ? 5'(16 + row) : 5'(row);
            exp_q.push_back({mk(7'd16, 5'(pe), acc, 3'b100, 5'd0), 32'd0, 32'd0});
          end
        end
      end
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_kernel_size = c.ks; cfg_data_type = c.dt; cfg_layer_type = c.lt;
    cfg_kernel_333 = c.k333; cfg_k_count = c.k; cfg_h_count = c.h; cfg_w_count = c.w;
    cfg_h_stride = c.hs; cfg_w_stride = c.ws; cfg_ch_count = c.ch; cfg_w_offset = c.wo;
    cfg_acc_shift = c.sh; cfg_addr2_start = c.a2; cfg_relu_mode = c.relu;
    cfg_relu_addr = c.ra;
  endtask

  task automatic drive_garbage();
    cfg_kernel_size = 4'($urandom); cfg_data_type = 2'($urandom);
    cfg_layer_type = 1'($urandom); cfg_kernel_333 = 1'($urandom);
    cfg_k_count = 10'($urandom); cfg_h_count = 16'($urandom); cfg_w_count = 16'($urandom);
    cfg_h_stride = 16'($urandom); cfg_w_stride = 16'($urandom);
    cfg_ch_count = 16'($urandom); cfg_w_offset = 16'($urandom);
    cfg_acc_shift = 5'($urandom); cfg_addr2_start = $urandom;
    cfg_relu_mode = 1'($urandom); cfg_relu_addr = $urandom;
  endtask

  // Runs one layer. stall: random cmd_ready; garbage: start held high and cfg
  // inputs scrambled after the start pulse; stop_after>0 abandons the run once
  // that many commands have been accepted (used for the mid-run reset).
  task automatic run(input cfg_t c, input bit stall, input bit garbage,
                     input int exp_n, input int stop_after);
    int n_acc = 0;
    bit got_done = 1'b0;
    logic [95:0] e;
    build_model(c);
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (garbage) begin
        start = 1'b1;
        drive_garbage();
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        chk("busy_low_at_done", 96'(busy), 96'd0);
        chk("queue_empty_at_done", 96'(exp_q.size()), 96'd0);
        break;
      end
      cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_cmd", 96'(cmd_valid), 96'd0);
        end else if (cmd_ready) begin
          e = exp_q.pop_front();
          if (n_acc == 0) chk("first_inst", 96'(cmd_inst), 96'h8000000B);
          chk("cmd", {cmd_inst, cmd_rs1, cmd_rs2}, e);
          n_acc++;
          if (stop_after > 0 && n_acc == stop_after) break;
        end else begin
          chk("stall_hold", {cmd_inst, cmd_rs1, cmd_rs2}, exp_q[0]);
        end
      end
    end
    if (stop_after == 0) begin
      chk("done_seen", 96'(got_done), 96'd1);
      chk("cmd_count", 96'(n_acc), 96'(exp_n));
      start = 1'b0;
      drive_cfg(c);
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("idle_after_done", {93'd0, busy, done, cmd_valid}, 96'd0);
    end
  endtask

  cfg_t ca, cb, cc, cd;

  initial begin
    ca = '{ks: 4'd3, dt: 2'd1, lt: 1'b0, k333: 1'b0, k: 10'd1, h: 16'd1, w: 16'd1,
           hs: 16'd0, ws: 16'd0, ch: 16'd0, wo: 16'd0, sh: 16'd0, a2: 32'd0,
           relu: 1'b0, ra: 32'd0};
    ca.hs = 16'd64; ca.ws = 16'd8; ca.ch = 16'd32; ca.wo = 16'd5; ca.sh = 5'd7;
    ca.a2 = 32'h0001_0000;
    cb = ca; cb.h = 16'd2;
    cc = cb; cc.relu = 1'b1; cc.ra = 32'd128;
    cd = ca; cd.k333 = 1'b1; cd.a2 = 32'h400; cd.h = 16'd4; cd.hs = 16'd6;
    cd.relu = 1'b1; cd.w = 16'd2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_inst, cmd_rs1, cmd_rs2[31:3], busy, done, cmd_valid},
        {cmd_inst & 32'd0, 32'd0, 29'd0, 3'b000});
    chk("reset_rs2", 96'(cmd_rs2), 96'd0);
    rst_n = 1'b1;

    // Readout, one tile
    run(ca, 1'b0, 1'b0, 263, 0);
    // Readout, two tiles along h
    run(cb, 1'b0, 1'b0, 391, 0);
    // Relu drain, two tiles
    run(cc, 1'b0, 1'b0, 151, 0);
    // 3x3x3 bases, relu, random stalls, start/cfg noise during the run
    run(cd, 1'b1, 1'b1, 135 + 2 * 4 * 8, 0);
    // Zero tile count: MATRIX straight to DONE
    cb.k = 10'd0;
    run(cb, 1'b1, 1'b0, 135, 0);

    // Reset in the middle of WACC, then replay from the start
    run(ca, 1'b0, 1'b0, 263, 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {cmd_inst, cmd_rs1, cmd_rs2}, 96'd0);
    chk("midrun_reset_flags", {93'd0, busy, done, cmd_valid}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(ca, 1'b1, 1'b0, 263, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
